axi4_rdonly_slave_mem: RTL



---
 rtl/axi4_rdonly_slave_mem_if.sv | 35 +++
 rtl/axi4_rdonly_slave_mem.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/axi4_rdonly_slave_mem_if.sv
// AXI4 read-channel bundle (AR + R) between a read master and the read-only memory slave.
interface axi4_rdonly_slave_mem_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [31:0]           araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [1:0]            arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arregion;
  logic [3:0]            arqos;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  araddr, arlen, arsize, arburst, arlock, arcache, arprot, arregion, arqos, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output araddr, arlen, arsize, arburst, arlock, arcache, arprot, arregion, arqos, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4_rdonly_slave_mem.sv
// AXI4 read-only memory slave: FIXED/INCR/WRAP bursts, registered R beats, side-band init port.
// Define AXI_RDSLAVE_AR_SKID_EN to add a one-entry AR skid for back-to-back bursts.
module axi4_rdonly_slave_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  axi4_rdonly_slave_mem_if.slave       S_AXI,
  input  logic                         init_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] init_addr,
  input  logic [DATA_WIDTH-1:0]        init_data
);
  localparam int unsigned AW      = $clog2(MEM_DEPTH);
  localparam int unsigned SizeMax = $clog2(DATA_WIDTH / 8);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e                state_q, state_d;
  logic [31:0]           addr_q;
  logic [7:0]            len_q, beat_cnt_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q, arready_q, arready_d;

  logic                  load;
  logic [31:0]           ld_addr, ld_off, ld_widx, adv_addr, step, wrap_bytes, wrap_lower;
  logic [7:0]            ld_len, ld_cnt;
  logic [2:0]            ld_size;
  logic [1:0]            ld_burst;
  logic                  decerr, slverr, wrap_len_ok;
  logic [DATA_WIDTH-1:0] beat_rdata;
  logic [1:0]            beat_rresp;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic ar_hs;
  logic unused_ar;
  assign ar_hs     = S_AXI.arvalid && arready_q;
  assign unused_ar = ^{S_AXI.arlock, S_AXI.arcache, S_AXI.arprot, S_AXI.arregion, S_AXI.arqos};

`ifdef AXI_RDSLAVE_AR_SKID_EN
  logic        skid_valid_q, skid_valid_d, skid_load;
  logic [31:0] skid_addr_q;
  logic [7:0]  skid_len_q;
  logic [2:0]  skid_size_q;
  logic [1:0]  skid_burst_q;
`endif

  assign S_AXI.arready = arready_q;
  assign S_AXI.rvalid  = (state_q == StBurst);
  assign S_AXI.rdata   = rdata_q;
  assign S_AXI.rresp   = rresp_q;
  assign S_AXI.rlast   = rlast_q;

  // Address of the beat after the current one
  always_comb begin
    step       = 32'd1 << size_q;
    wrap_bytes = (32'(len_q) + 32'd1) << size_q;
    wrap_lower = addr_q & ~(wrap_bytes - 32'd1);
    case (burst_q)
      2'b00:   adv_addr = addr_q;
      2'b10: begin
        adv_addr = addr_q + step;
        if (adv_addr == wrap_lower + wrap_bytes) adv_addr = wrap_lower;
      end
      default: adv_addr = addr_q + step;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    ld_addr  = adv_addr;
    ld_len   = len_q;
    ld_size  = size_q;
    ld_burst = burst_q;
    ld_cnt   = beat_cnt_q + 8'd1;
`ifdef AXI_RDSLAVE_AR_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_load    = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (ar_hs) begin
          load     = 1'b1;
          ld_addr  = S_AXI.araddr;
          ld_len   = S_AXI.arlen;
          ld_size  = S_AXI.arsize;
          ld_burst = S_AXI.arburst;
          ld_cnt   = 8'd0;
          state_d  = StBurst;
        end
      end
      StBurst: begin
`ifdef AXI_RDSLAVE_AR_SKID_EN
        if (ar_hs) begin
          skid_load    = 1'b1;
          skid_valid_d = 1'b1;
        end
`endif
        if (S_AXI.rready) begin
          if (!rlast_q) begin
            load = 1'b1;
          end else begin
`ifdef AXI_RDSLAVE_AR_SKID_EN
            if (skid_valid_q) begin
              load         = 1'b1;
              ld_addr      = skid_addr_q;
              ld_len       = skid_len_q;
              ld_size      = skid_size_q;
              ld_burst     = skid_burst_q;
              ld_cnt       = 8'd0;
              skid_valid_d = 1'b0;
            end else if (ar_hs) begin
              // AR arriving on the last beat bypasses the skid entirely
              load         = 1'b1;
              ld_addr      = S_AXI.araddr;
              ld_len       = S_AXI.arlen;
              ld_size      = S_AXI.arsize;
              ld_burst     = S_AXI.arburst;
              ld_cnt       = 8'd0;
              skid_load    = 1'b0;
              skid_valid_d = 1'b0;
            end else begin
              state_d = StIdle;
            end
`else
            state_d = StIdle;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef AXI_RDSLAVE_AR_SKID_EN
    arready_d = (state_d == StIdle) || !skid_valid_d;
`else
    arready_d = (state_d == StIdle);
`endif
  end

  // Response and data for the beat being loaded; first matching rule wins
  assign ld_off      = ld_addr - BASE_ADDR;
  assign ld_widx     = ld_off >> SizeMax;
  assign decerr      = (ld_addr < BASE_ADDR) || (ld_widx >= MEM_DEPTH);
  assign wrap_len_ok = (ld_len == 8'd1) || (ld_len == 8'd3) || (ld_len == 8'd7) ||
                       (ld_len == 8'd15);
  assign slverr      = (ld_size > 3'(SizeMax)) || (ld_burst == 2'b11) ||
                       ((ld_burst == 2'b10) && !wrap_len_ok);

  always_comb begin
    beat_rdata = '0;
    beat_rresp = 2'b00;
    if (decerr)      beat_rresp = 2'b11;
    else if (slverr) beat_rresp = 2'b10;
    else             beat_rdata = mem[ld_widx[AW-1:0]];
  end

  always_ff @(posedge ACLK) begin
    if (init_we) mem[init_addr] <= init_data;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= StIdle;
      arready_q  <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      rlast_q    <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      if (load) begin
        addr_q     <= ld_addr;
        len_q      <= ld_len;
        size_q     <= ld_size;
        burst_q    <= ld_burst;
        beat_cnt_q <= ld_cnt;
        rdata_q    <= beat_rdata;
        rresp_q    <= beat_rresp;
        rlast_q    <= (ld_cnt == ld_len);
      end else if (state_d == StIdle) begin
        rlast_q <= 1'b0;
      end
    end
  end

`ifdef AXI_RDSLAVE_AR_SKID_EN
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      skid_valid_q <= 1'b0;
      skid_addr_q  <= '0;
      skid_len_q   <= '0;
      skid_size_q  <= '0;
      skid_burst_q <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      if (skid_load) begin
        skid_addr_q  <= S_AXI.araddr;
        skid_len_q   <= S_AXI.arlen;
        skid_size_q  <= S_AXI.arsize;
        skid_burst_q <= S_AXI.arburst;
      end
    end
  end
`endif
endmodule
